// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the VGA game blocks. It holds the
//               one-hot direction encodings, the screen and player geometry
//               and the player motion state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

   // Push-button direction encodings (one-hot)
   localparam logic [3:0] DIR_U = 4'b1000;
   localparam logic [3:0] DIR_D = 4'b0100;
   localparam logic [3:0] DIR_R = 4'b0010;
   localparam logic [3:0] DIR_L = 4'b0001;

   // Screen and player geometry in pixels
   localparam int GAME_SCREEN_W    = 640;
   localparam int GAME_SCREEN_H    = 480;
   localparam int GAME_PLAYER_SIZE = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COMMIT = 2'd2
   } motion_state_t;

   // True only for the four legal single-direction button codes
   function automatic logic is_valid_dir(input logic [3:0] dir);
      return (dir == DIR_U) || (dir == DIR_D) || (dir == DIR_R) || (dir == DIR_L);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pos_wrap_step.sv
`default_nettype none
// ============================================================================
// Module      : pos_wrap_step
// Description : Combinational one-step position update with screen
//               wrap-around. All arithmetic is unsigned 32-bit. A move that
//               would leave the screen wraps to the opposite edge.
// Ports       : dir     in  4  one-hot direction (U/D/R/L); other codes hold
//               h_pos   in  32 current top-left x
//               v_pos   in  32 current top-left y
//               next_h  out 32 stepped/wrapped x
//               next_v  out 32 stepped/wrapped y
// Revision    : 1.0 - initial release
// ============================================================================
module pos_wrap_step
   import game_pkg::*;
#(
   parameter int SCREEN_W    = GAME_SCREEN_W,
   parameter int SCREEN_H    = GAME_SCREEN_H,
   parameter int PLAYER_SIZE = GAME_PLAYER_SIZE,
   parameter int STEP        = 1
) (
   input  logic [3:0]  dir,
   input  logic [31:0] h_pos,
   input  logic [31:0] v_pos,
   output logic [31:0] next_h,
   output logic [31:0] next_v
);

   localparam logic [31:0] C_W    = 32'(SCREEN_W);
   localparam logic [31:0] C_H    = 32'(SCREEN_H);
   localparam logic [31:0] C_SIZE = 32'(PLAYER_SIZE);
   localparam logic [31:0] C_STEP = 32'(STEP);

   always_comb begin
      next_h = h_pos;
      next_v = v_pos;
      case (dir)
         // Compare before subtracting so the unsigned value never underflows
         DIR_U: next_v = (v_pos >= C_STEP) ? (v_pos - C_STEP) : (C_H - C_SIZE);
         DIR_D: next_v = ((v_pos + C_SIZE + C_STEP) <= C_H) ? (v_pos + C_STEP) : 32'd0;
         DIR_L: next_h = (h_pos >= C_STEP) ? (h_pos - C_STEP) : (C_W - C_SIZE);
         DIR_R: next_h = ((h_pos + C_SIZE + C_STEP) <= C_W) ? (h_pos + C_STEP) : 32'd0;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_motion_ctrl
// Description : Player movement sequencer. It samples the button direction
//               on a movement tick and waits SETTLE_CYC cycles for the
//               rectangle collision enables to settle. It then commits or
//               rejects a one-step move with screen wrap-around.
// Ports       : btnClk       in  1      clock
//               rst_n        in  1      synchronous active-low reset
//               move_tick    in  1      single-cycle movement strobe
//               btns         in  4      one-hot direction (8=U 4=D 2=R 1=L)
//               up_en..right_en in N_RECT per-rectangle direction enables
//               player_hPos  out 32     registered player x
//               player_vPos  out 32     registered player y
//               move_dir     out 4      latched direction, 0 when idle
//               busy         out 1      high while a move is in progress
//               blocked      out 1      one-cycle pulse on rejected move
//               drop_cnt     out 8      saturating count of ignored ticks
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion_ctrl
   import game_pkg::*;
#(
   parameter int N_RECT      = 8,
   parameter int SCREEN_W    = GAME_SCREEN_W,
   parameter int SCREEN_H    = GAME_SCREEN_H,
   parameter int PLAYER_SIZE = GAME_PLAYER_SIZE,
   parameter int STEP        = 1,
   parameter int SETTLE_CYC  = 2,
   parameter int H0          = 314,
   parameter int V0          = 234
) (
   input  logic              btnClk,
   input  logic              rst_n,
   input  logic              move_tick,
   input  logic [3:0]        btns,
   input  logic [N_RECT-1:0] up_en,
   input  logic [N_RECT-1:0] down_en,
   input  logic [N_RECT-1:0] left_en,
   input  logic [N_RECT-1:0] right_en,
   output logic [31:0]       player_hPos,
   output logic [31:0]       player_vPos,
   output logic [3:0]        move_dir,
   output logic              busy,
   output logic              blocked,
   output logic [7:0]        drop_cnt
);

   // Counter only needs to hold SETTLE_CYC-1
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   motion_state_t    state;
   logic [CNT_W-1:0] settle_cnt;
   logic [31:0]      next_h;
   logic [31:0]      next_v;
   logic             allowed;

   pos_wrap_step #(
      .SCREEN_W    (SCREEN_W),
      .SCREEN_H    (SCREEN_H),
      .PLAYER_SIZE (PLAYER_SIZE),
      .STEP        (STEP)
   ) u_pos_wrap_step (
      .dir    (move_dir),
      .h_pos  (player_hPos),
      .v_pos  (player_vPos),
      .next_h (next_h),
      .next_v (next_v)
   );

   // A move is allowed only if every rectangle agrees
   always_comb begin
      allowed = 1'b0;
      case (move_dir)
         DIR_U:   allowed = &up_en;
         DIR_D:   allowed = &down_en;
         DIR_R:   allowed = &right_en;
         DIR_L:   allowed = &left_en;
         default: allowed = 1'b0;
      endcase
   end

   always_ff @(posedge btnClk) begin
      if (!rst_n) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         player_hPos <= 32'(H0);
         player_vPos <= 32'(V0);
         move_dir    <= 4'd0;
         busy        <= 1'b0;
         blocked     <= 1'b0;
         drop_cnt    <= 8'd0;
      end else begin
         blocked <= 1'b0;

         // Any tick outside IDLE (including the COMMIT cycle) is dropped
         if (move_tick && (state != IDLE) && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (move_tick) begin
                  if (is_valid_dir(btns)) begin
                     move_dir   <= btns;
                     settle_cnt <= CNT_LOAD;
                     busy       <= 1'b1;
                     state      <= SETTLE;
                  end else begin
                     move_dir <= 4'd0;
                  end
               end
            end

            SETTLE: begin
               if (settle_cnt == '0)
                  state <= COMMIT;
               else
                  settle_cnt <= settle_cnt - CNT_ONE;
            end

            COMMIT: begin
               if (allowed) begin
                  player_hPos <= next_h;
                  player_vPos <= next_v;
               end else begin
                  blocked <= 1'b1;
               end
               move_dir <= 4'd0;
               busy     <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               move_dir <= 4'd0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_motion_ctrl
// Description : Self-checking bench for player_motion_ctrl. Two instances:
//               dut0 with the default reset position, dut1 starting at (0,0)
//               for wrap-around. Expected commits are queued when a tick is
//               accepted and compared when busy falls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion_ctrl;
   import game_pkg::*;

   localparam int NR = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, rst_w;
   logic          tick0, tick1;
   logic [3:0]    btns0, btns1;
   logic [NR-1:0] up_en, down_en, left_en, right_en;
   logic [31:0]   h0, v0, h1, v1;
   logic [3:0]    dir0, dir1;
   logic          busy0, busy1, blk0, blk1;
   logic [7:0]    drop0, drop1;

   player_motion_ctrl #(.N_RECT(NR)) dut0 (
      .btnClk(clk), .rst_n(rst_n), .move_tick(tick0), .btns(btns0),
      .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
      .player_hPos(h0), .player_vPos(v0), .move_dir(dir0),
      .busy(busy0), .blocked(blk0), .drop_cnt(drop0)
   );

   player_motion_ctrl #(.N_RECT(NR), .H0(0), .V0(0)) dut1 (
      .btnClk(clk), .rst_n(rst_w), .move_tick(tick1), .btns(btns1),
      .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
      .player_hPos(h1), .player_vPos(v1), .move_dir(dir1),
      .busy(busy1), .blocked(blk1), .drop_cnt(drop1)
   );

   typedef struct {
      logic [31:0] h;
      logic [31:0] v;
      logic        blk;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_h[2], m_v[2], m_phase[2], m_drop[2];
   bit abort0 = 1'b0;
   logic prev_busy0 = 1'b0;
   logic prev_busy1 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference step with wrap, straight from the screen geometry 640x480, size 12, step 1
   function automatic void f_wrap(input logic [3:0] d, input int h, input int v,
                                  output int nh, output int nv);
      nh = h;
      nv = v;
      case (d)
         4'b1000: nv = (v >= 1) ? v - 1 : 480 - 12;
         4'b0100: nv = (v + 12 + 1 <= 480) ? v + 1 : 0;
         4'b0010: nh = (h + 12 + 1 <= 640) ? h + 1 : 0;
         4'b0001: nh = (h >= 1) ? h - 1 : 640 - 12;
         default: ;
      endcase
   endfunction

   function automatic bit f_allowed(input logic [3:0] d);
      case (d)
         4'b1000: return up_en    == {NR{1'b1}};
         4'b0100: return down_en  == {NR{1'b1}};
         4'b0010: return right_en == {NR{1'b1}};
         4'b0001: return left_en  == {NR{1'b1}};
         default: return 1'b0;
      endcase
   endfunction

   // Drive one cycle of stimulus at the falling edge and advance the model
   task automatic drive(input int inst, input bit tk, input logic [3:0] b);
      int nh, nv;
      bit ok;
      exp_t e;
      @(negedge clk);
      if (inst == 0) begin tick0 = tk; btns0 = b; end
      else           begin tick1 = tk; btns1 = b; end
      if (m_phase[inst] == 0) begin
         if (tk && (b == 4'b1000 || b == 4'b0100 || b == 4'b0010 || b == 4'b0001)) begin
            ok = f_allowed(b);
            f_wrap(b, m_h[inst], m_v[inst], nh, nv);
            if (ok) begin
               m_h[inst] = nh;
               m_v[inst] = nv;
            end
            e.h   = 32'(m_h[inst]);
            e.v   = 32'(m_v[inst]);
            e.blk = !ok;
            e.cyc = cyc + 4;
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
            m_phase[inst] = 3;
         end
      end else begin
         if (tk && m_drop[inst] < 255) m_drop[inst]++;
         m_phase[inst]--;
      end
   endtask

   // Commit monitors: compare on each falling edge of busy
   always @(negedge clk) begin : mon0
      exp_t e;
      if (prev_busy0 === 1'b1 && busy0 === 1'b0) begin
         checks++;
         if (abort0) begin
            abort0 = 1'b0;
            if (blk0 !== 1'b0 || h0 !== 32'd314 || v0 !== 32'd234) begin
               errors++;
               $display("FAIL abort0: got blk=%0b pos=(%0d,%0d) want blk=0 pos=(314,234)", blk0, h0, v0);
            end
         end else if (q0.size() == 0) begin
            errors++;
            $display("FAIL commit0_unexpected: busy fell at cycle %0d with nothing expected", cyc);
         end else begin
            e = q0.pop_front();
            if (h0 !== e.h || v0 !== e.v || blk0 !== e.blk || cyc != e.cyc) begin
               errors++;
               $display("FAIL commit0: got pos=(%0d,%0d) blk=%0b cyc=%0d want pos=(%0d,%0d) blk=%0b cyc=%0d",
                        h0, v0, blk0, cyc, e.h, e.v, e.blk, e.cyc);
            end
         end
      end
      prev_busy0 = busy0;
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (prev_busy1 === 1'b1 && busy1 === 1'b0) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL commit1_unexpected: busy fell at cycle %0d with nothing expected", cyc);
         end else begin
            e = q1.pop_front();
            if (h1 !== e.h || v1 !== e.v || blk1 !== e.blk || cyc != e.cyc) begin
               errors++;
               $display("FAIL commit1: got pos=(%0d,%0d) blk=%0b cyc=%0d want pos=(%0d,%0d) blk=%0b cyc=%0d",
                        h1, v1, blk1, cyc, e.h, e.v, e.blk, e.cyc);
            end
         end
      end
      prev_busy1 = busy1;
   end

   task automatic test_reset();
      rst_n = 1'b0;
      rst_w = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rst_w = 1'b1;
      checks++;
      if (h0 !== 32'd314 || v0 !== 32'd234 || busy0 !== 1'b0 || drop0 !== 8'd0 ||
          dir0 !== 4'd0 || blk0 !== 1'b0) begin
         errors++;
         $display("FAIL reset0: got pos=(%0d,%0d) busy=%0b drop=%0d dir=%0h blk=%0b want (314,234) 0 0 0 0",
                  h0, v0, busy0, drop0, dir0, blk0);
      end
      checks++;
      if (h1 !== 32'd0 || v1 !== 32'd0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset1: got pos=(%0d,%0d) busy=%0b want (0,0) 0", h1, v1, busy1);
      end
      repeat (20) drive(0, 1'b0, 4'd0);
      checks++;
      if (h0 !== 32'd314 || v0 !== 32'd234 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: got pos=(%0d,%0d) busy=%0b want (314,234) 0", h0, v0, busy0);
      end
   endtask

   task automatic test_free_move();
      drive(0, 1'b1, DIR_R);
      drive(0, 1'b0, 4'd0);
      checks++;
      if (busy0 !== 1'b1 || dir0 !== DIR_R) begin
         errors++;
         $display("FAIL free_busy_rise: got busy=%0b dir=%0h want 1 2", busy0, dir0);
      end
      drive(0, 1'b0, 4'd0);
      drive(0, 1'b0, 4'd0);
      checks++;
      if (busy0 !== 1'b1 || h0 !== 32'd314) begin
         errors++;
         $display("FAIL free_early: got busy=%0b h=%0d want 1 314", busy0, h0);
      end
      drive(0, 1'b0, 4'd0);
      checks++;
      if (h0 !== 32'd315 || busy0 !== 1'b0 || blk0 !== 1'b0 || dir0 !== 4'd0) begin
         errors++;
         $display("FAIL free_done: got h=%0d busy=%0b blk=%0b dir=%0h want 315 0 0 0", h0, busy0, blk0, dir0);
      end
   endtask

   task automatic test_blocked();
      up_en[5] = 1'b0;
      drive(0, 1'b1, DIR_U);
      repeat (4) drive(0, 1'b0, 4'd0);
      checks++;
      if (blk0 !== 1'b1 || v0 !== 32'd234) begin
         errors++;
         $display("FAIL blocked_pulse: got blk=%0b v=%0d want 1 234", blk0, v0);
      end
      drive(0, 1'b0, 4'd0);
      checks++;
      if (blk0 !== 1'b0 || v0 !== 32'd234) begin
         errors++;
         $display("FAIL blocked_width: got blk=%0b v=%0d want 0 234", blk0, v0);
      end
      up_en = '1;
   endtask

   task automatic test_invalid();
      drive(0, 1'b1, 4'b1010);
      drive(0, 1'b0, 4'd0);
      checks++;
      if (busy0 !== 1'b0 || dir0 !== 4'd0) begin
         errors++;
         $display("FAIL invalid_btns: got busy=%0b dir=%0h want 0 0", busy0, dir0);
      end
      repeat (4) drive(0, 1'b0, 4'd0);
      checks++;
      if (h0 !== 32'd315 || v0 !== 32'd234 || drop0 !== 8'd0) begin
         errors++;
         $display("FAIL invalid_nomove: got pos=(%0d,%0d) drop=%0d want (315,234) 0", h0, v0, drop0);
      end
   endtask

   task automatic test_back_to_back();
      drive(0, 1'b1, DIR_R);
      drive(0, 1'b1, DIR_R);
      repeat (4) drive(0, 1'b0, 4'd0);
      checks++;
      if (drop0 !== 8'd1 || h0 !== 32'd316) begin
         errors++;
         $display("FAIL back_to_back: got drop=%0d h=%0d want 1 316", drop0, h0);
      end
   endtask

   task automatic test_saturate();
      repeat (400) drive(0, 1'b1, DIR_R);
      repeat (5) drive(0, 1'b0, 4'd0);
      checks++;
      if (drop0 !== 8'd255 || h0 !== 32'(m_h[0])) begin
         errors++;
         $display("FAIL drop_saturate: got drop=%0d h=%0d want 255 %0d", drop0, h0, m_h[0]);
      end
   endtask

   task automatic wrap_step(input logic [3:0] d, input logic [31:0] wh, input logic [31:0] wv);
      drive(1, 1'b1, d);
      repeat (5) drive(1, 1'b0, 4'd0);
      checks++;
      if (h1 !== wh || v1 !== wv) begin
         errors++;
         $display("FAIL wrap_%0h: got (%0d,%0d) want (%0d,%0d)", d, h1, v1, wh, wv);
      end
   endtask

   task automatic test_wrap();
      wrap_step(DIR_L, 32'd628, 32'd0);
      wrap_step(DIR_U, 32'd628, 32'd468);
      wrap_step(DIR_D, 32'd628, 32'd0);
      wrap_step(DIR_R, 32'd0,   32'd0);
   endtask

   task automatic test_reset_mid_move();
      drive(0, 1'b1, DIR_D);
      void'(q0.pop_back());
      m_phase[0] = 0;
      @(negedge clk);
      tick0  = 1'b0;
      rst_n  = 1'b0;
      abort0 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      m_h[0] = 314;
      m_v[0] = 234;
      m_drop[0] = 0;
      checks++;
      if (busy0 !== 1'b0 || dir0 !== 4'd0 || drop0 !== 8'd0) begin
         errors++;
         $display("FAIL midreset_state: got busy=%0b dir=%0h drop=%0d want 0 0 0", busy0, dir0, drop0);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b0, 4'd0);
         checks++;
         if (blk0 !== 1'b0 || h0 !== 32'd314 || v0 !== 32'd234 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: got blk=%0b pos=(%0d,%0d) busy=%0b want 0 (314,234) 0",
                     blk0, h0, v0, busy0);
         end
      end
   endtask

   initial begin
      tick0 = 1'b0; tick1 = 1'b0;
      btns0 = 4'd0; btns1 = 4'd0;
      up_en = '1; down_en = '1; left_en = '1; right_en = '1;
      m_h[0] = 314; m_v[0] = 234; m_h[1] = 0; m_v[1] = 0;
      m_phase[0] = 0; m_phase[1] = 0; m_drop[0] = 0; m_drop[1] = 0;

      test_reset();
      test_free_move();
      test_blocked();
      test_invalid();
      test_back_to_back();
      test_saturate();
      test_wrap();
      test_reset_mid_move();

      repeat (3) drive(0, 1'b0, 4'd0);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL pending_commits: got %0d/%0d outstanding want 0/0", q0.size(), q1.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
